// File: rtl/hynoc_local_packetizer_if.sv
// Bus bundle between the packetizer, its payload source and the HyNoC
// local ingress FIFO. "master" is the packetizer side, "slave" is the
// surrounding logic (payload producer plus ingress FIFO).
interface hynoc_local_packetizer_if #(
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1
) ();

  // Payload stream into the packetizer
  logic                     s_valid;
  logic                     s_ready;
  logic [PAYLOAD_WIDTH-1:0] s_data;
  logic                     s_last;

  // Flit stream into the local ingress FIFO, plus its occupancy feedback
  logic                     local_ingress_write;
  logic [FLIT_WIDTH-1:0]    local_ingress_data;
  logic [LOG2_FIFO_DEPTH:0] local_ingress_fifo_level;

  modport master (
    input  s_valid,
    output s_ready,
    input  s_data,
    input  s_last,
    output local_ingress_write,
    output local_ingress_data,
    input  local_ingress_fifo_level
  );

  modport slave (
    output s_valid,
    input  s_ready,
    output s_data,
    output s_last,
    input  local_ingress_write,
    input  local_ingress_data,
    output local_ingress_fifo_level
  );

endinterface

// File: rtl/hynoc_local_packetizer.sv
// HyNoC local packetizer: turns a valid/ready/last payload stream into
// header + payload flits with a tail marker, throttled by the ingress FIFO
// level. Streams longer than MAX_PACKET_FLITS are split into several
// packets, and each packet re-sends the header latched when the stream started.
module hynoc_local_packetizer #(
  parameter int LOG2_FIFO_DEPTH  = 5,
  parameter int PAYLOAD_WIDTH    = 32,
  parameter int FLIT_WIDTH       = PAYLOAD_WIDTH + 1,
  parameter int NB_ADDRESS_FLITS = 1,
  parameter int MAX_PACKET_FLITS = 1024,
  parameter int FIFO_MARGIN      = 4
) (
  input  logic                                   local_clk,
  input  logic                                   local_srst,
  input  logic [NB_ADDRESS_FLITS*FLIT_WIDTH-1:0] address_flits,
  hynoc_local_packetizer_if.master               bus,
  output logic                                   packet_sent,
  output logic                                   busy,
  output logic [15:0]                            packet_count
);

  localparam int ACW = (NB_ADDRESS_FLITS > 1) ? $clog2(NB_ADDRESS_FLITS) : 1;
  localparam int FCW = (MAX_PACKET_FLITS > 1) ? $clog2(MAX_PACKET_FLITS) : 1;
  localparam logic [ACW-1:0] LAST_ADDR = ACW'(NB_ADDRESS_FLITS - 1);
  localparam logic [FCW-1:0] LAST_FLIT = FCW'(MAX_PACKET_FLITS - 1);
  // Writes are allowed only while the FIFO keeps FIFO_MARGIN entries free
  localparam logic [LOG2_FIFO_DEPTH:0] LEVEL_LIMIT =
    (LOG2_FIFO_DEPTH + 1)'(2**LOG2_FIFO_DEPTH - FIFO_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_PAYLOAD
  } state_t;

  state_t                r_state;
  logic [FLIT_WIDTH-1:0] r_hdr [NB_ADDRESS_FLITS];
  logic [ACW-1:0]        r_addr_cnt;
  logic [FCW-1:0]        r_flit_cnt;
  logic                  r_write;
  logic [FLIT_WIDTH-1:0] r_data;
  logic                  r_sent;
  logic [15:0]           r_count;

  logic                  w_space;
  logic                  w_accept;
  logic                  w_tail;
  logic [FLIT_WIDTH-1:0] w_hdr_flit;

  assign w_space   = bus.local_ingress_fifo_level < LEVEL_LIMIT;
  assign bus.s_ready = (r_state == S_PAYLOAD) && w_space;
  assign w_accept  = bus.s_ready && bus.s_valid;
  assign w_tail    = bus.s_last || (r_flit_cnt == LAST_FLIT);

  // Select the header slice addressed by r_addr_cnt, tail marker cleared
  always_comb begin
    // NOTE: default assignment first so no path leaves w_hdr_flit unassigned (no latch).
    w_hdr_flit = '0;
    for (int i = 0; i < NB_ADDRESS_FLITS; i++) begin
      if (r_addr_cnt == ACW'(i)) w_hdr_flit = r_hdr[i];
    end
    w_hdr_flit[FLIT_WIDTH-1] = 1'b0;
  end

  // Capture the routing header when a stream starts; reused across splits
  always_ff @(posedge local_clk) begin
    // NOTE: pure data storage, never read before it is loaded, so it has no reset.
    if (r_state == S_IDLE && bus.s_valid) begin
      for (int i = 0; i < NB_ADDRESS_FLITS; i++) begin
        r_hdr[i] <= address_flits[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  // Packetizer FSM with registered flit output, tail pulse and packet counter
  always_ff @(posedge local_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (local_srst) begin
      r_state    <= S_IDLE;
      r_addr_cnt <= '0;
      r_flit_cnt <= '0;
      r_write    <= 1'b0;
      r_data     <= '0;
      r_sent     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_write <= 1'b0;
      r_sent  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.s_valid) begin
            r_state    <= S_ADDR;
            r_addr_cnt <= '0;
          end
        end
        S_ADDR: begin
          if (w_space) begin
            r_write <= 1'b1;
            r_data  <= w_hdr_flit;
            if (r_addr_cnt == LAST_ADDR) begin
              r_state <= S_PAYLOAD;
            end else begin
              r_addr_cnt <= r_addr_cnt + ACW'(1);
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_write <= 1'b1;
            r_data  <= {w_tail, bus.s_data};
            if (w_tail) begin
              r_sent     <= 1'b1;
              r_count    <= r_count + 16'd1;
              r_flit_cnt <= '0;
              r_addr_cnt <= '0;
              r_state    <= bus.s_last ? S_IDLE : S_ADDR;
            end else begin
              r_flit_cnt <= r_flit_cnt + FCW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.local_ingress_write = r_write;
  assign bus.local_ingress_data  = r_data;
  assign packet_sent  = r_sent;
  assign busy         = (r_state != S_IDLE);
  assign packet_count = r_count;

endmodule

// File: tb/tb_hynoc_local_packetizer.sv
// Directed bench for hynoc_local_packetizer. dut_a (1 header flit, 4 payload
// flits per packet) runs a cycle table: basic stream, backpressure, splitting
// with header changes, and the last-on-max-flit corner. Hand-written
// sequences cover reset mid-packet and the 2-header-flit ordering on dut_b.
module tb_hynoc_local_packetizer;

  localparam logic [32:0] H1  = 33'h1_2345_6789;
  localparam logic [32:0] HF1 = 33'h0_2345_6789;
  localparam logic [32:0] H2  = 33'h1_FFFF_0000;
  localparam logic [32:0] HF2 = 33'h0_FFFF_0000;

  logic        clk;
  logic        local_srst;
  logic [32:0] addr_a;
  logic [65:0] addr_b;
  logic        sent_a, busy_a, sent_b, busy_b;
  logic [15:0] count_a, count_b;

  int checks   = 0;
  int failures = 0;

  hynoc_local_packetizer_if #(.LOG2_FIFO_DEPTH(5), .PAYLOAD_WIDTH(32)) bus_a ();
  hynoc_local_packetizer_if #(.LOG2_FIFO_DEPTH(5), .PAYLOAD_WIDTH(32)) bus_b ();

  hynoc_local_packetizer #(
    .LOG2_FIFO_DEPTH(5), .PAYLOAD_WIDTH(32), .NB_ADDRESS_FLITS(1),
    .MAX_PACKET_FLITS(4), .FIFO_MARGIN(4)
  ) dut_a (
    .local_clk(clk), .local_srst(local_srst), .address_flits(addr_a),
    .bus(bus_a), .packet_sent(sent_a), .busy(busy_a), .packet_count(count_a)
  );

  hynoc_local_packetizer #(
    .LOG2_FIFO_DEPTH(5), .PAYLOAD_WIDTH(32), .NB_ADDRESS_FLITS(2),
    .MAX_PACKET_FLITS(1024), .FIFO_MARGIN(4)
  ) dut_b (
    .local_clk(clk), .local_srst(local_srst), .address_flits(addr_b),
    .bus(bus_b), .packet_sent(sent_b), .busy(busy_b), .packet_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic [5:0]  lv;
    logic [32:0] ad;
    logic        er;
    logic        ew;
    logic [32:0] ed;
    logic        es;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic [5:0] lv,
                              logic [32:0] ad, logic er, logic ew, logic [32:0] ed,
                              logic es, logic eb, logic [15:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.lv = lv; t.ad = ad;
    t.er = er; t.ew = ew; t.ed = ed; t.es = es; t.eb = eb; t.ec = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle on dut_a: drive at negedge, check s_ready, then registered outputs
  task automatic step_a(input string tag, input logic v, input logic [31:0] d,
                        input logic l, input logic [5:0] lv, input logic [32:0] ad,
                        input logic er, input logic ew, input logic [32:0] ed,
                        input logic es, input logic eb, input logic [15:0] ec);
    @(negedge clk);
    bus_a.s_valid = v;
    bus_a.s_data  = d;
    bus_a.s_last  = l;
    bus_a.local_ingress_fifo_level = lv;
    addr_a = ad;
    #1;
    check({tag, " s_ready"}, bus_a.s_ready, er);
    @(posedge clk);
    #1;
    check({tag, " write"}, bus_a.local_ingress_write, ew);
    check({tag, " data"}, bus_a.local_ingress_data, ed);
    check({tag, " packet_sent"}, sent_a, es);
    check({tag, " busy"}, busy_a, eb);
    check({tag, " packet_count"}, count_a, ec);
  endtask

  task automatic step_b(input string tag, input logic v, input logic [31:0] d,
                        input logic l, input logic er, input logic ew,
                        input logic [32:0] ed, input logic es, input logic eb,
                        input logic [15:0] ec);
    @(negedge clk);
    bus_b.s_valid = v;
    bus_b.s_data  = d;
    bus_b.s_last  = l;
    #1;
    check({tag, " s_ready"}, bus_b.s_ready, er);
    @(posedge clk);
    #1;
    check({tag, " write"}, bus_b.local_ingress_write, ew);
    check({tag, " data"}, bus_b.local_ingress_data, ed);
    check({tag, " packet_sent"}, sent_b, es);
    check({tag, " busy"}, busy_b, eb);
    check({tag, " packet_count"}, count_b, ec);
  endtask

  initial begin
    local_srst = 1'b1;
    addr_a = '0;
    addr_b = '0;
    bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.s_last = 1'b0;
    bus_a.local_ingress_fifo_level = '0;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.s_last = 1'b0;
    bus_b.local_ingress_fifo_level = '0;

    // Basic 3-word stream A,B,C
    vecs.push_back(mk(1, 32'hAAAA0001, 0, 0,  H1, 0, 0, 33'h0,            0, 1, 0));
    vecs.push_back(mk(1, 32'hAAAA0001, 0, 0,  H1, 0, 1, HF1,              0, 1, 0));
    vecs.push_back(mk(1, 32'hAAAA0001, 0, 0,  H1, 1, 1, {1'b0, 32'hAAAA0001}, 0, 1, 0));
    vecs.push_back(mk(1, 32'hBBBB0002, 0, 0,  H1, 1, 1, {1'b0, 32'hBBBB0002}, 0, 1, 0));
    vecs.push_back(mk(1, 32'hCCCC0003, 1, 0,  H1, 1, 1, {1'b1, 32'hCCCC0003}, 1, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0,  H1, 0, 0, {1'b1, 32'hCCCC0003}, 0, 0, 1));
    // Backpressure: level 28 blocks, 27 lets through
    vecs.push_back(mk(1, 32'h000000D0, 0, 28, H1, 0, 0, {1'b1, 32'hCCCC0003}, 0, 1, 1));
    vecs.push_back(mk(1, 32'h000000D0, 0, 28, H1, 0, 0, {1'b1, 32'hCCCC0003}, 0, 1, 1));
    vecs.push_back(mk(1, 32'h000000D0, 0, 27, H1, 0, 1, HF1,              0, 1, 1));
    vecs.push_back(mk(1, 32'h000000D0, 0, 28, H1, 0, 0, HF1,              0, 1, 1));
    vecs.push_back(mk(1, 32'h000000D0, 0, 27, H1, 1, 1, {1'b0, 32'h000000D0}, 0, 1, 1));
    vecs.push_back(mk(1, 32'hD1D1D1D1, 1, 28, H1, 0, 0, {1'b0, 32'h000000D0}, 0, 1, 1));
    vecs.push_back(mk(1, 32'hD1D1D1D1, 1, 0,  H1, 1, 1, {1'b1, 32'hD1D1D1D1}, 1, 0, 2));
    vecs.push_back(mk(0, 32'h0,        0, 0,  H1, 0, 0, {1'b1, 32'hD1D1D1D1}, 0, 0, 2));
    // 10-word stream split 4/4/2; header input changes after latching
    vecs.push_back(mk(1, 32'h10000000, 0, 0,  H1, 0, 0, {1'b1, 32'hD1D1D1D1}, 0, 1, 2));
    vecs.push_back(mk(1, 32'h10000000, 0, 0,  H1, 0, 1, HF1,              0, 1, 2));
    vecs.push_back(mk(1, 32'h10000000, 0, 0,  H2, 1, 1, {1'b0, 32'h10000000}, 0, 1, 2));
    vecs.push_back(mk(1, 32'h10000001, 0, 0,  H2, 1, 1, {1'b0, 32'h10000001}, 0, 1, 2));
    vecs.push_back(mk(1, 32'h10000002, 0, 0,  H2, 1, 1, {1'b0, 32'h10000002}, 0, 1, 2));
    vecs.push_back(mk(1, 32'h10000003, 0, 0,  H2, 1, 1, {1'b1, 32'h10000003}, 1, 1, 3));
    vecs.push_back(mk(1, 32'h10000004, 0, 0,  H2, 0, 1, HF1,              0, 1, 3));
    vecs.push_back(mk(1, 32'h10000004, 0, 0,  H2, 1, 1, {1'b0, 32'h10000004}, 0, 1, 3));
    vecs.push_back(mk(1, 32'h10000005, 0, 0,  H2, 1, 1, {1'b0, 32'h10000005}, 0, 1, 3));
    vecs.push_back(mk(1, 32'h10000006, 0, 0,  H2, 1, 1, {1'b0, 32'h10000006}, 0, 1, 3));
    vecs.push_back(mk(1, 32'h10000007, 0, 0,  H2, 1, 1, {1'b1, 32'h10000007}, 1, 1, 4));
    vecs.push_back(mk(1, 32'h10000008, 0, 0,  H2, 0, 1, HF1,              0, 1, 4));
    vecs.push_back(mk(1, 32'h10000008, 0, 0,  H2, 1, 1, {1'b0, 32'h10000008}, 0, 1, 4));
    vecs.push_back(mk(1, 32'h10000009, 1, 0,  H2, 1, 1, {1'b1, 32'h10000009}, 1, 0, 5));
    vecs.push_back(mk(0, 32'h0,        0, 0,  H2, 0, 0, {1'b1, 32'h10000009}, 0, 0, 5));
    // s_last on the 4th (max) flit: single tail, no empty split packet
    vecs.push_back(mk(1, 32'hF0F00000, 0, 0,  H2, 0, 0, {1'b1, 32'h10000009}, 0, 1, 5));
    vecs.push_back(mk(1, 32'hF0F00000, 0, 0,  H2, 0, 1, HF2,              0, 1, 5));
    vecs.push_back(mk(1, 32'hF0F00000, 0, 0,  H2, 1, 1, {1'b0, 32'hF0F00000}, 0, 1, 5));
    vecs.push_back(mk(1, 32'hF0F00001, 0, 0,  H2, 1, 1, {1'b0, 32'hF0F00001}, 0, 1, 5));
    vecs.push_back(mk(1, 32'hF0F00002, 0, 0,  H2, 1, 1, {1'b0, 32'hF0F00002}, 0, 1, 5));
    vecs.push_back(mk(1, 32'hF0F00003, 1, 0,  H2, 1, 1, {1'b1, 32'hF0F00003}, 1, 0, 6));
    vecs.push_back(mk(0, 32'h0,        0, 0,  H2, 0, 0, {1'b1, 32'hF0F00003}, 0, 0, 6));
    vecs.push_back(mk(0, 32'h0,        0, 0,  H2, 0, 0, {1'b1, 32'hF0F00003}, 0, 0, 6));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset write", bus_a.local_ingress_write, 1'b0);
    check("reset data", bus_a.local_ingress_data, 33'h0);
    check("reset s_ready", bus_a.s_ready, 1'b0);
    check("reset packet_sent", sent_a, 1'b0);
    check("reset busy", busy_a, 1'b0);
    check("reset packet_count", count_a, 16'd0);
    check("reset b busy", busy_b, 1'b0);
    @(negedge clk);
    local_srst = 1'b0;

    foreach (vecs[i]) begin
      step_a($sformatf("v%0d", i), vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].lv,
             vecs[i].ad, vecs[i].er, vecs[i].ew, vecs[i].ed, vecs[i].es,
             vecs[i].eb, vecs[i].ec);
    end

    // Reset in PAYLOAD after two accepted words, then a clean new stream
    step_a("r0", 1, 32'h66660000, 0, 0, H1, 0, 0, {1'b1, 32'hF0F00003}, 0, 1, 6);
    step_a("r1", 1, 32'h66660000, 0, 0, H1, 0, 1, HF1,                  0, 1, 6);
    step_a("r2", 1, 32'h66660000, 0, 0, H1, 1, 1, {1'b0, 32'h66660000}, 0, 1, 6);
    step_a("r3", 1, 32'h66660001, 0, 0, H1, 1, 1, {1'b0, 32'h66660001}, 0, 1, 6);
    local_srst = 1'b1;
    step_a("r4", 1, 32'h66660002, 0, 0, H1, 1, 0, 33'h0,                0, 0, 0);
    local_srst = 1'b0;
    step_a("r5", 1, 32'h66660002, 1, 0, H2, 0, 0, 33'h0,                0, 1, 0);
    step_a("r6", 1, 32'h66660002, 1, 0, H2, 0, 1, HF2,                  0, 1, 0);
    step_a("r7", 1, 32'h66660002, 1, 0, H2, 1, 1, {1'b1, 32'h66660002}, 1, 0, 1);

    // Two header flits: slice 0 first, both MSBs forced low
    addr_b = {33'h1_0000_0B0B, 33'h1_0000_0A0A};
    step_b("b0", 1, 32'h5A5A5A5A, 1, 0, 0, 33'h0,                0, 1, 0);
    addr_b = {33'h1_1111_1111, 33'h1_2222_2222};
    step_b("b1", 1, 32'h5A5A5A5A, 1, 0, 1, 33'h0_0000_0A0A,      0, 1, 0);
    step_b("b2", 1, 32'h5A5A5A5A, 1, 0, 1, 33'h0_0000_0B0B,      0, 1, 0);
    step_b("b3", 1, 32'h5A5A5A5A, 1, 1, 1, {1'b1, 32'h5A5A5A5A}, 1, 0, 1);
    step_b("b4", 0, 32'h0,        0, 0, 0, {1'b1, 32'h5A5A5A5A}, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
